bin2bcd_seq: RTL and testbench

Parametrised, iterative binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It processes one input bit per clock cycle and uses a valid/ready handshake on both input and output. It supersedes the fixed 8-bit combinational converter in display and readout paths where input width exceeds 8 bits or area matters more than latency. It also reports an overflow flag when the result does not fit in the configured number of digits.

---
 rtl/bin2bcd_seq.sv | 97 +++++++++
 tb/tb_bin2bcd_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Valid/ready handshake on both sides, with a sticky overflow flag when the digits run out.
module bin2bcd_seq #(
    parameter int IN_W   = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_ovf,
    output logic                  busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t            state, state_next;
    logic [IN_W-1:0]   bin_reg, bin_next;
    logic [BCD_W-1:0]  bcd_reg, bcd_next, bcd_adj;
    logic              ovf_reg, ovf_next;
    logic [CNT_W-1:0]  cnt, cnt_next;

    // Digits are always <= 9 here, so the corrected value never exceeds 12.
    always_comb begin
        bcd_adj = bcd_reg;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_reg[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd_reg[4*k +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_next = state;
        bin_next   = bin_reg;
        bcd_next   = bcd_reg;
        ovf_next   = ovf_reg;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    bin_next   = in_bin;
                    bcd_next   = '0;
                    ovf_next   = 1'b0;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // A bit falling off the top digit means the value is >= 10^DIGITS.
                {bcd_next, bin_next} = {bcd_adj[BCD_W-2:0], bin_reg, 1'b0};
                ovf_next = ovf_reg | bcd_adj[BCD_W-1];
                cnt_next = cnt + CNT_W'(1);
                if (cnt == CNT_W'(IN_W - 1))
                    state_next = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bin_reg <= '0;
            bcd_reg <= '0;
            ovf_reg <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= state_next;
            bin_reg <= bin_next;
            bcd_reg <= bcd_next;
            ovf_reg <= ovf_next;
            cnt     <= cnt_next;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_bcd   = bcd_reg;
    assign out_ovf   = ovf_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: three instances (8/3, 8/2, 16/5) exercised one at a time.
// Stimulus pushes expected results; a negedge monitor pops and compares on each output handshake.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  in_valid;
    logic [2:0]  out_ready;
    logic [31:0] in_bin [3];
    logic [2:0]  ir, ov, bz, of;
    logic [11:0] bcd0;
    logic [7:0]  bcd1;
    logic [19:0] bcd2;

    typedef struct {
        int          dut;
        logic [39:0] bcd;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   rise_log[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   lat [3] = '{8, 8, 16};
    logic [2:0] ov_prev = 3'b000;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin2bcd_seq #(.IN_W(8), .DIGITS(3)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(ir[0]),
        .in_bin(in_bin[0][7:0]), .out_valid(ov[0]), .out_ready(out_ready[0]),
        .out_bcd(bcd0), .out_ovf(of[0]), .busy(bz[0]));

    bin2bcd_seq #(.IN_W(8), .DIGITS(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(ir[1]),
        .in_bin(in_bin[1][7:0]), .out_valid(ov[1]), .out_ready(out_ready[1]),
        .out_bcd(bcd1), .out_ovf(of[1]), .busy(bz[1]));

    bin2bcd_seq #(.IN_W(16), .DIGITS(5)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(ir[2]),
        .in_bin(in_bin[2][15:0]), .out_valid(ov[2]), .out_ready(out_ready[2]),
        .out_bcd(bcd2), .out_ovf(of[2]), .busy(bz[2]));

    function automatic logic [39:0] ob(input int k);
        case (k)
            0:       ob = {28'd0, bcd0};
            1:       ob = {32'd0, bcd1};
            default: ob = {20'd0, bcd2};
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic applyStimulus(input int d, input logic [31:0] v, input logic [39:0] ebcd,
                                 input logic eovf, input bit push, input bit keep);
        exp_t e;
        int   n = 0;
        while (!ir[d] && n < 200) begin
            tick(1);
            n++;
        end
        checkOutput($sformatf("in_ready_wait_dut%0d", d), {39'd0, ir[d]}, 40'd1);
        in_valid[d] = 1'b1;
        in_bin[d]   = v;
        tick(1);
        if (push) begin
            e.dut = d;
            e.bcd = ebcd;
            e.ovf = eovf;
            e.acc = cyc;
            exp_q.push_back(e);
        end
        if (!keep) in_valid[d] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick(1);
            n++;
        end
        checkOutput("drain_timeout", 40'(exp_q.size()), 40'd0);
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ov[k] && !ov_prev[k]) begin
                if (exp_q.size() == 0 || exp_q[0].dut != k)
                    checkOutput($sformatf("unexpected_valid_dut%0d", k), 40'd1, 40'd0);
                else
                    checkOutput($sformatf("latency_dut%0d", k), 40'(cyc - exp_q[0].acc), 40'(lat[k]));
                if (k == 0) rise_log.push_back(cyc);
            end
            if (ov[k] && out_ready[k]) begin
                if (exp_q.size() == 0 || exp_q[0].dut != k) begin
                    checkOutput($sformatf("unexpected_result_dut%0d", k), 40'd1, 40'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput($sformatf("bcd_dut%0d", k), ob(k), e.bcd);
                    checkOutput($sformatf("ovf_dut%0d", k), {39'd0, of[k]}, {39'd0, e.ovf});
                end
            end
            ov_prev[k] = ov[k];
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int valid_seen;
        rst       = 1'b1;
        in_valid  = 3'b000;
        out_ready = 3'b111;
        for (int k = 0; k < 3; k++) in_bin[k] = '0;
        tick(2);

        // reset values on all instances
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("rst_in_ready_dut%0d", k),  {39'd0, ir[k]}, 40'd1);
            checkOutput($sformatf("rst_out_valid_dut%0d", k), {39'd0, ov[k]}, 40'd0);
            checkOutput($sformatf("rst_busy_dut%0d", k),      {39'd0, bz[k]}, 40'd0);
            checkOutput($sformatf("rst_bcd_dut%0d", k),       ob(k),          40'd0);
            checkOutput($sformatf("rst_ovf_dut%0d", k),       {39'd0, of[k]}, 40'd0);
        end
        rst = 1'b0;
        tick(1);

        $display("[TB] default params, basic values");
        applyStimulus(0, 0,   40'h000, 1'b0, 1, 0); drain();
        applyStimulus(0, 255, 40'h255, 1'b0, 1, 0); drain();
        applyStimulus(0, 99,  40'h099, 1'b0, 1, 0); drain();
        applyStimulus(0, 123, 40'h123, 1'b0, 1, 0);
        checkOutput("busy_after_accept", {39'd0, bz[0]}, 40'd1);
        checkOutput("in_ready_after_accept", {39'd0, ir[0]}, 40'd0);
        drain();

        $display("[TB] overflow with two digits");
        applyStimulus(1, 123, 40'h23, 1'b1, 1, 0); drain();
        applyStimulus(1, 99,  40'h99, 1'b0, 1, 0); drain();
        applyStimulus(1, 100, 40'h00, 1'b1, 1, 0); drain();

        $display("[TB] wide operand");
        applyStimulus(2, 65535, 40'h65535, 1'b0, 1, 0); drain();
        applyStimulus(2, 10000, 40'h10000, 1'b0, 1, 0); drain();
        applyStimulus(2, 1,     40'h00001, 1'b0, 1, 0); drain();

        $display("[TB] backpressure and ignored input");
        out_ready[0] = 1'b0;
        applyStimulus(0, 200, 40'h200, 1'b0, 1, 0);
        tick(2);
        in_valid[0] = 1'b1;
        in_bin[0]   = 77;
        tick(1);
        in_valid[0] = 1'b0;
        begin
            int n = 0;
            while (!ov[0] && n < 100) begin
                tick(1);
                n++;
            end
        end
        checkOutput("bp_valid_seen", {39'd0, ov[0]}, 40'd1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_bcd_hold", ob(0), 40'h200);
            checkOutput("bp_in_ready_low", {39'd0, ir[0]}, 40'd0);
            checkOutput("bp_valid_hold", {39'd0, ov[0]}, 40'd1);
            tick(1);
        end
        out_ready[0] = 1'b1;
        drain();
        valid_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (ov[0]) valid_seen++;
        end
        checkOutput("bp_no_second_result", 40'(valid_seen), 40'd0);

        $display("[TB] back-to-back");
        rise_log.delete();
        applyStimulus(0, 12,  40'h012, 1'b0, 1, 1);
        applyStimulus(0, 37,  40'h037, 1'b0, 1, 1);
        applyStimulus(0, 200, 40'h200, 1'b0, 1, 0);
        drain();
        checkOutput("b2b_count", 40'(rise_log.size()), 40'd3);
        if (rise_log.size() == 3) begin
            checkOutput("b2b_spacing1", 40'(rise_log[1] - rise_log[0]), 40'd10);
            checkOutput("b2b_spacing2", 40'(rise_log[2] - rise_log[1]), 40'd10);
        end

        $display("[TB] reset during shift");
        applyStimulus(0, 123, 40'h0, 1'b0, 0, 0);
        tick(2);
        rst = 1'b1;
        tick(1);
        checkOutput("midrst_in_ready",  {39'd0, ir[0]}, 40'd1);
        checkOutput("midrst_out_valid", {39'd0, ov[0]}, 40'd0);
        checkOutput("midrst_busy",      {39'd0, bz[0]}, 40'd0);
        checkOutput("midrst_bcd",       ob(0),          40'd0);
        checkOutput("midrst_ovf",       {39'd0, of[0]}, 40'd0);
        rst = 1'b0;
        valid_seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (ov[0]) valid_seen++;
        end
        checkOutput("midrst_no_valid", 40'(valid_seen), 40'd0);
        applyStimulus(0, 5, 40'h005, 1'b0, 1, 0);
        drain();

        tick(5);
        checkOutput("queue_empty", 40'(exp_q.size()), 40'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
